uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_mmio.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared FSM encodings, register offsets and STATUS bit indices.
// Macro UART_TX_PARITY_EN adds the PARITY state. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVERRUN = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo: byte FIFO with occupancy count; full/empty judged on pre-edge count.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [STAT_CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [STAT_CNT_W-1:0] count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == STAT_CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// uart_tx_mmio: memory-mapped UART transmitter (TXDATA/STATUS) with TX FIFO.
// Define UART_TX_PARITY_EN for an even parity bit (11-bit frame). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o
);

  localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);

  state_e                state_q, state_d;
  logic [15:0]           div_q, div_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            data_q, data_d;
  logic                  tx_q, tx_d;
  logic                  ovr_q, ovr_d;

  logic                  hit_tx, hit_status, push, pop, tick;
  logic                  fifo_full, fifo_empty;
  logic [7:0]            fifo_rdata;
  logic [STAT_CNT_W-1:0] fifo_count;
  logic [2:0]            next_bit;
  logic                  unused_data_hi;

  assign hit_tx         = (addr_i == BASE_ADDR + OFF_TXDATA);
  assign hit_status     = (addr_i == BASE_ADDR + OFF_STATUS);
  assign push           = we_i && hit_tx && !fifo_full;
  assign tick           = (div_q == '0);
  assign next_bit       = bit_q + 3'd1;
  assign tx_o           = tx_q;
  assign unused_data_hi = ^data_i[31:8];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (data_i[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A dropped write outranks a same-cycle STATUS clear
  always_comb begin
    ovr_d = ovr_q;
    if (we_i && hit_tx && fifo_full) ovr_d = 1'b1;
    else if (we_i && hit_status)     ovr_d = 1'b0;
  end

  always_comb begin
    data_o = '0;
    if (hit_status) begin
      data_o[STAT_FULL]                   = fifo_full;
      data_o[STAT_EMPTY]                  = fifo_empty;
      data_o[STAT_BUSY]                   = (state_q != ST_IDLE);
      data_o[STAT_OVERRUN]                = ovr_q;
      data_o[STAT_CNT_LSB +: STAT_CNT_W]  = fifo_count;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != ST_IDLE) begin
      div_d = tick ? DIV_RELOAD : div_q - 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          div_d   = DIV_RELOAD;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_d   = 3'd0;
          tx_d    = data_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^data_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = next_bit;
            tx_d  = data_q[next_bit];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          bit_d   = 3'd0;
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_mmio: scoreboard bench; stimulus queues expected bytes, a serial
// monitor decodes each frame on tx_o and checks it. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_mmio;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;
  localparam logic [31:0] A_TX = 32'h0000_1000;
  localparam logic [31:0] A_ST = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        tx_o;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_mmio #(.BASE_ADDR(32'h0000_1000), .CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_o   (tx_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] d);
    logic [FRAME-1:0] w;
    for (int c = 0; c < FRAME; c++) begin
      int b;
      b = c / DIV;
      if (b == 0)                w[c] = 1'b0;
      else if (b <= 8)           w[c] = d[b-1];
      else if (b == NBITS - 1)   w[c] = 1'b1;
      else                       w[c] = ^d;
    end
    return w;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i = 1'b1; addr_i = a; data_i = d;
    @(posedge clk);
    #1;
    we_i = 1'b0; addr_i = '0; data_i = '0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    addr_i = a;
    #1;
    check(name, data_o, exp);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n <= 2000; n++) begin
      @(negedge clk);
      addr_i = A_ST;
      #1;
      if (data_o == 32'h002) break;
      if (n == 2000) check({name, " idle timeout"}, data_o, 32'h002);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic hold_high(input int cycles, input string name);
    logic seen_low;
    seen_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) seen_low = 1'b1;
    end
    check(name, {31'b0, seen_low}, 32'h0);
  endtask

  // Serial monitor: every non-aborted frame is compared cycle by cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i === 1'b1 && tx_o === 1'b0) begin
        logic [FRAME-1:0] wave;
        logic [7:0]       got, exp;
        logic             aborted;
        wave = '0; got = '0; aborted = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
          if (c != 0) @(negedge clk);
          if (rst_i !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          wave[c] = tx_o;
          if (c / DIV >= 1 && c / DIV <= 8 && c % DIV == DIV / 2) got[c/DIV-1] = tx_o;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_frame: got 0x%0h expected no frame", got);
          end else begin
            exp = exp_q.pop_front();
            check("frame_data", {24'b0, got}, {24'b0, exp});
            tests++;
            if (wave !== exp_wave(exp)) begin
              fails++;
              $display("FAIL frame_wave: got 0x%0h expected 0x%0h", wave, exp_wave(exp));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_i = A_ST;
    repeat (3) @(negedge clk);
    #1;
    check("reset_tx", {31'b0, tx_o}, 32'h1);
    check("reset_status", data_o, 32'h002);
    @(negedge clk);
    rst_i = 1'b1;
    rd_chk(A_ST, 32'h002, "status_after_reset");

    // Single frame 0x55 and pop/start timing
    exp_q.push_back(8'h55);
    wr(A_TX, 32'h55);
    addr_i = A_ST;
    #1;
    check("tx_before_pop", {31'b0, tx_o}, 32'h1);
    check("status_queued", data_o, 32'h010);
    @(posedge clk);
    #1;
    check("tx_start", {31'b0, tx_o}, 32'h0);
    check("status_busy", data_o, 32'h006);
    rd_chk(A_TX, 32'h0, "txdata_read");
    wait_idle("frame55");
    rd_chk(A_ST, 32'h002, "status_after_55");

    // Overrun: six back-to-back writes, sixth dropped
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) wr(A_TX, 32'(i));
    rd_chk(A_ST, 32'h04D, "status_overrun");
    wr(A_ST, 32'h0);
    rd_chk(A_ST, 32'h045, "status_ovr_cleared");
    wait_idle("burst");
    rd_chk(A_ST, 32'h002, "status_after_burst");

    // Unmapped addresses
    rd_chk(32'h0000_1008, 32'h0, "read_1008");
    rd_chk(32'h0000_0FFC, 32'h0, "read_0FFC");
    wr(32'h0000_1008, 32'h55);
    rd_chk(A_ST, 32'h002, "status_after_bad_write");
    hold_high(20, "tx_idle_after_bad_write");

    // Upper data bits ignored
    exp_q.push_back(8'hFF);
    wr(A_TX, 32'hABCD_EFFF);
    wait_idle("frameFF");

    // Reset in the middle of a frame with two bytes queued
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    wr(A_TX, 32'hA3);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    repeat (13) @(negedge clk);
    check("tx_data_bit2_low", {31'b0, tx_o}, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    check("tx_high_in_reset", {31'b0, tx_o}, 32'h1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    rd_chk(A_ST, 32'h002, "status_after_midreset");
    hold_high(60, "no_frame_after_reset");
    rd_chk(A_ST, 32'h002, "status_still_idle");

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
